ram_writer: RTL
===============

RAM_WRITER -- requirements
Module: ram_writer

Interface
REQ-001 Parameter ADDR_W SHALL default to 5 and set the RAM address width (32 words).
REQ-002 Parameter DATA_W SHALL default to 4 and set the RAM data width.
REQ-003 chosenClock  in  1  SHALL be the block clock (the same clock that drives the read-side address counter).
REQ-004 reset  in  1  SHALL be a synchronous, active-high reset; clock chosenClock.
REQ-005 wr_key  in  1  SHALL be an asynchronous, active-high write request from a pushbutton that has already been inverted.
REQ-006 sw_addr  in  ADDR_W  SHALL be the requested write address from switches.
REQ-007 sw_data  in  DATA_W  SHALL be the requested write data from switches.
REQ-008 wren  out  1  SHALL be the single-cycle write enable driven to the RAM write port.
REQ-009 wraddr  out  ADDR_W  SHALL be the registered write address.
REQ-010 wrdata  out  DATA_W  SHALL be the registered write data.
REQ-011 busy  out  1  SHALL be high whenever the FSM is not in IDLE.
REQ-012 wr_count  out  8  SHALL count completed writes.

Function
REQ-013 wr_key SHALL pass through a 2-flop synchronizer; only the synchronized signal key_s is used downstream.
REQ-014 The FSM SHALL have exactly three states: IDLE, WRITE and HOLD.
REQ-015 IDLE with key_s=1: at the next edge the FSM SHALL capture sw_addr/sw_data into wraddr/wrdata and go to WRITE.
REQ-016 WRITE: wren SHALL be 1 for exactly this one cycle; at the next edge wr_count SHALL increment and the FSM SHALL go to HOLD.
REQ-017 HOLD: the FSM SHALL stay in HOLD while key_s=1 and return to IDLE on the first edge that samples key_s=0.
REQ-018 If wr_key is held high for any duration, it SHALL produce exactly one wren pulse per press.
REQ-019 Latency: with wr_key first sampled high at edge k, wren SHALL be high in the cycle between edges k+2 and k+3.
REQ-020 wraddr and wrdata SHALL stay stable from the capture edge until the next capture, so switch changes during WRITE or HOLD SHALL have no effect.
REQ-021 wr_count SHALL wrap from 255 to 0 without saturation.
REQ-022 A press shorter than 2 cycles, which never reaches key_s, SHALL produce no write.

Reset
REQ-023 On reset: wren=0, wraddr=0, wrdata=0, wr_count=0, and the synchronizer flops are cleared.
REQ-024 On reset the FSM SHALL enter HOLD, so busy=1 until key_s=0 is seen.
REQ-025 A key held across reset SHALL NOT cause a write.
REQ-026 Reset asserted during WRITE SHALL force wren=0 from the next edge and SHALL NOT increment wr_count.

Configuration
REQ-027 Macro RAM_WRITER_AUTOINC_EN, when defined, SHALL add an internal ADDR_W pointer (reset 0).
REQ-028 With the macro defined, IDLE->WRITE SHALL capture the pointer into wraddr and ignore sw_addr.
REQ-029 With the macro defined, the pointer SHALL increment on leaving WRITE and wrap from 31 to 0.
REQ-030 Without the macro, the pointer SHALL NOT exist and wraddr SHALL be captured from sw_addr.

Structure
REQ-031 Package ram_writer_pkg SHALL hold the state enum type (IDLE/WRITE/HOLD) and the default ADDR_W/DATA_W constants.
REQ-032 The 2-flop synchronizer SHALL be a sub-module named input_sync, reset to 0.

Verification
REQ-033 Reset 2 cycles; sw_addr=5'd7, sw_data=4'hA; raise wr_key for 20 cycles -> one wren pulse at edge k+2 with wraddr=7, wrdata=A; wr_count=1.
REQ-034 Hold wr_key high through reset release -> no wren pulse; busy stays 1 until wr_key=0, then busy=0.
REQ-035 Change sw_data to 4'h3 during HOLD -> wrdata remains A; a second press then writes 3 and wr_count=2.
REQ-036 Apply a 1-cycle wr_key glitch between edges -> no wren pulse and wr_count unchanged.
REQ-037 Assert reset in the WRITE cycle -> wren=0 next cycle and wr_count=0.
REQ-038 With RAM_WRITER_AUTOINC_EN, 33 presses -> wraddr sequence 0..31 then 0, and wr_count=33.

Source files
------------

// File: rtl/ram_writer_pkg.sv
// Shared types and defaults for the pushbutton-driven RAM write port.
// No logic here; state encoding and default widths only.
package ram_writer_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 4;
    localparam int COUNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/input_sync.sv
// Two-flop synchronizer for an asynchronous level input, cleared to 0 on reset.
// Latency: two chosenClock edges. No backpressure; free-running sampler.
// Reset: synchronous, active-high.
module input_sync (
    input  logic chosenClock,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge chosenClock) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/ram_writer.sv
// Turns each pushbutton press into exactly one single-cycle RAM write of the switch address/data.
// Latency: wr_key first sampled at edge k gives wren between edges k+2 and k+3.
// Backpressure: none; a press held for any length yields one write, busy marks non-IDLE.
// Option RAM_WRITER_AUTOINC_EN: write address comes from an internal wrapping pointer instead of sw_addr.
module ram_writer
    import ram_writer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic               chosenClock,
    input  logic               reset,
    input  logic               wr_key,
    input  logic [ADDR_W-1:0]  sw_addr,
    input  logic [DATA_W-1:0]  sw_data,
    output logic               wren,
    output logic [ADDR_W-1:0]  wraddr,
    output logic [DATA_W-1:0]  wrdata,
    output logic               busy,
    output logic [COUNT_W-1:0] wr_count
);

    logic               w_key_s;
    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_capture;
    logic               w_commit;
    logic [1:0]         r_primed;
    logic [ADDR_W-1:0]  r_wraddr;
    logic [DATA_W-1:0]  r_wrdata;
    logic [COUNT_W-1:0] r_wr_count;
    logic [ADDR_W-1:0]  w_addr_src;

    input_sync u_key_sync (
        .chosenClock (chosenClock),
        .reset       (reset),
        .i_async     (wr_key),
        .o_sync      (w_key_s)
    );

`ifdef RAM_WRITER_AUTOINC_EN
    logic [ADDR_W-1:0] r_ptr;
    logic              w_unused_sw_addr;

    assign w_unused_sw_addr = ^sw_addr;
    assign w_addr_src       = r_ptr;

    always_ff @(posedge chosenClock) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_commit) begin
            r_ptr <= r_ptr + ADDR_W'(1);
        end
    end
`else
    assign w_addr_src = sw_addr;
`endif

    // The synchronizer reads 0 for two edges after reset regardless of the
    // button, so HOLD ignores key_s until it reflects the real input; a key
    // held across reset therefore cannot look like a fresh press.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_key_s) begin
                    w_state_nxt = WRITE;
                    w_capture   = 1'b1;
                end
            end
            WRITE: begin
                w_state_nxt = HOLD;
                w_commit    = 1'b1;
            end
            HOLD: begin
                if (!w_key_s && r_primed[1]) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = HOLD;
        endcase
    end

    always_ff @(posedge chosenClock) begin
        if (reset) begin
            r_state    <= HOLD;
            r_primed   <= 2'b00;
            r_wraddr   <= '0;
            r_wrdata   <= '0;
            r_wr_count <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_primed <= {r_primed[0], 1'b1};
            if (w_capture) begin
                r_wraddr <= w_addr_src;
                r_wrdata <= sw_data;
            end
            if (w_commit) begin
                r_wr_count <= r_wr_count + COUNT_W'(1);
            end
        end
    end

    assign wren     = (r_state == WRITE);
    assign busy     = (r_state != IDLE);
    assign wraddr   = r_wraddr;
    assign wrdata   = r_wrdata;
    assign wr_count = r_wr_count;

endmodule
